// File: rtl/cpu_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : cpu_control_fsm
// Description : Multi-cycle control sequencer for a small RV32I-style core.
//               Steps each instruction through fetch, decode/execute and an
//               optional data-memory access. It issues memory strobes,
//               register write enables and datapath mux selects. A
//               per-access timeout turns a hung memory into a terminal FAULT.
//               EBREAK-style SYSTEM instructions stop the core in HALT.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   TIMEOUT_CYCLES : waiting cycles without mem_rdy before FAULT (1..65535)
// Configuration macro
//   CTRL_CYCLE_CSR_EN : when defined, adds a 32-bit free-running cycle
//                       counter on output port cycle_count. SYSTEM
//                       instructions with funct3 != 000 then write it back
//                       (wb_sel = 101). When undefined, those instructions
//                       only advance the PC.
// Ports
//   clk          in   clock, all state updates on the rising edge
//   rst          in   synchronous active-high reset
//   op_class     in   one-hot class flags {isLoad,isALUimm,isStore,isALUreg,
//                     isSYSTEM,isJAL,isJALR,isLUI,isAUIPC,isBranch}
//                     (bit 9 = isLoad)
//   funct3       in   funct3 field of the latched instruction
//   take_branch  in   branch comparison result, meaningful in EXECUTE
//   mem_rdy      in   single-cycle memory response / ack
//   mem_rstrb    out  memory read request pulse
//   mem_wstrb    out  memory write request pulse
//   instr_we     out  instruction register load
//   pc_we        out  program counter update
//   rf_we        out  register file write
//   pc_sel       out  00 PC+4, 01 PC+imm, 10 (rs1+imm)&~1
//   wb_sel       out  000 ALU, 001 MEM, 010 PC+4, 011 IMM, 100 PC+imm,
//                     101 CYCLES
//   state        out  current state encoding
//   halted       out  high in HALT
//   fault        out  high in FAULT
//   cycle_count  out  free-running cycle counter (only with CTRL_CYCLE_CSR_EN)
// ============================================================================
module cpu_control_fsm #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  op_class,
  input  logic [2:0]  funct3,
  input  logic        take_branch,
  input  logic        mem_rdy,
  output logic        mem_rstrb,
  output logic        mem_wstrb,
  output logic        instr_we,
  output logic        pc_we,
  output logic        rf_we,
  output logic [1:0]  pc_sel,
  output logic [2:0]  wb_sel,
  output logic [2:0]  state,
  output logic        halted,
  output logic        fault
`ifdef CTRL_CYCLE_CSR_EN
  ,
  output logic [31:0] cycle_count
`endif
);

  typedef enum logic [2:0] {
    S_FETCH      = 3'd0,
    S_WAIT_INSTR = 3'd1,
    S_EXECUTE    = 3'd2,
    S_LOAD       = 3'd3,
    S_STORE      = 3'd4,
    S_WAIT_DATA  = 3'd5,
    S_HALT       = 3'd6,
    S_FAULT      = 3'd7
  } state_t;

  // pc_sel encodings
  localparam logic [1:0] c_PC_PLUS4 = 2'b00;
  localparam logic [1:0] c_PC_IMM   = 2'b01;
  localparam logic [1:0] c_PC_JALR  = 2'b10;

  // wb_sel encodings
  localparam logic [2:0] c_WB_ALU    = 3'b000;
  localparam logic [2:0] c_WB_MEM    = 3'b001;
  localparam logic [2:0] c_WB_PC4    = 3'b010;
  localparam logic [2:0] c_WB_IMM    = 3'b011;
  localparam logic [2:0] c_WB_PCIMM  = 3'b100;
`ifdef CTRL_CYCLE_CSR_EN
  localparam logic [2:0] c_WB_CYCLES = 3'b101;
`endif

  // The counter holds the number of waiting cycles already spent without
  // mem_rdy. A cycle that finds it at TIMEOUT_CYCLES-1, still without
  // mem_rdy, is the TIMEOUT_CYCLES-th such cycle and triggers FAULT.
  localparam logic [15:0] c_TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] wait_q,  wait_d;

  // Instruction class decode
  logic w_is_load, w_is_aluimm, w_is_store, w_is_alureg, w_is_system;
  logic w_is_jal, w_is_jalr, w_is_lui, w_is_auipc, w_is_branch;
  logic w_onehot;
  logic w_wait_expired;

  assign w_is_load   = op_class[9];
  assign w_is_aluimm = op_class[8];
  assign w_is_store  = op_class[7];
  assign w_is_alureg = op_class[6];
  assign w_is_system = op_class[5];
  assign w_is_jal    = op_class[4];
  assign w_is_jalr   = op_class[3];
  assign w_is_lui    = op_class[2];
  assign w_is_auipc  = op_class[1];
  assign w_is_branch = op_class[0];

  // x & (x-1) clears the lowest set bit, so a nonzero result means at least
  // two flags are set.
  assign w_onehot = (op_class != 10'd0) &&
                    ((op_class & (op_class - 10'd1)) == 10'd0);

  assign w_wait_expired = (wait_q == c_TIMEOUT_LAST);

  assign state = state_q;

  // --------------------------------------------------------------------------
  // State and wait-counter registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      wait_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

`ifdef CTRL_CYCLE_CSR_EN
  // --------------------------------------------------------------------------
  // Free-running cycle counter. It wraps naturally from 0xFFFFFFFF to 0.
  // --------------------------------------------------------------------------
  logic [31:0] cycle_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q <= 32'd0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
    end
  end

  assign cycle_count = cycle_q;
`endif

  // --------------------------------------------------------------------------
  // Next-state and output decode
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    mem_rstrb = 1'b0;
    mem_wstrb = 1'b0;
    instr_we  = 1'b0;
    pc_we     = 1'b0;
    rf_we     = 1'b0;
    pc_sel    = c_PC_PLUS4;
    wb_sel    = c_WB_ALU;
    halted    = 1'b0;
    fault     = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_rstrb = 1'b1;
        wait_d    = 16'd0;
        state_d   = S_WAIT_INSTR;
      end

      S_WAIT_INSTR: begin
        // mem_rdy wins over a timeout that expires in the same cycle
        if (mem_rdy) begin
          instr_we = 1'b1;
          state_d  = S_EXECUTE;
        end else if (w_wait_expired) begin
          state_d  = S_FAULT;
        end else begin
          wait_d   = wait_q + 16'd1;
        end
      end

      S_EXECUTE: begin
        if (!w_onehot) begin
          state_d = S_FAULT;
        end else if (w_is_load) begin
          state_d = S_LOAD;
        end else if (w_is_store) begin
          state_d = S_STORE;
        end else if (w_is_system && (funct3 == 3'b000)) begin
          state_d = S_HALT;
        end else begin
          // Single-cycle instructions retire here
          pc_we   = 1'b1;
          state_d = S_FETCH;
          if (w_is_aluimm || w_is_alureg) begin
            rf_we  = 1'b1;
            wb_sel = c_WB_ALU;
          end else if (w_is_jal) begin
            rf_we  = 1'b1;
            wb_sel = c_WB_PC4;
            pc_sel = c_PC_IMM;
          end else if (w_is_jalr) begin
            rf_we  = 1'b1;
            wb_sel = c_WB_PC4;
            pc_sel = c_PC_JALR;
          end else if (w_is_lui) begin
            rf_we  = 1'b1;
            wb_sel = c_WB_IMM;
          end else if (w_is_auipc) begin
            rf_we  = 1'b1;
            wb_sel = c_WB_PCIMM;
          end else if (w_is_branch) begin
            pc_sel = take_branch ? c_PC_IMM : c_PC_PLUS4;
          end else begin
            // SYSTEM with funct3 != 000: cycle CSR read or plain NOP
`ifdef CTRL_CYCLE_CSR_EN
            rf_we  = 1'b1;
            wb_sel = c_WB_CYCLES;
`endif
          end
        end
      end

      S_LOAD: begin
        mem_rstrb = 1'b1;
        wait_d    = 16'd0;
        state_d   = S_WAIT_DATA;
      end

      S_STORE: begin
        mem_wstrb = 1'b1;
        wait_d    = 16'd0;
        state_d   = S_WAIT_DATA;
      end

      S_WAIT_DATA: begin
        if (mem_rdy) begin
          pc_we   = 1'b1;
          pc_sel  = c_PC_PLUS4;
          rf_we   = w_is_load;
          wb_sel  = c_WB_MEM;
          state_d = S_FETCH;
        end else if (w_wait_expired) begin
          state_d = S_FAULT;
        end else begin
          wait_d  = wait_q + 16'd1;
        end
      end

      S_HALT: begin
        halted = 1'b1;
      end

      S_FAULT: begin
        fault = 1'b1;
      end

      default: begin
        state_d = S_FAULT;
      end
    endcase

    // While reset is held the state register may still hold an in-flight
    // transaction for this cycle. Silence every output so that nothing
    // retires or strobes.
    if (rst) begin
      mem_rstrb = 1'b0;
      mem_wstrb = 1'b0;
      instr_we  = 1'b0;
      pc_we     = 1'b0;
      rf_we     = 1'b0;
      pc_sel    = c_PC_PLUS4;
      wb_sel    = c_WB_ALU;
      halted    = 1'b0;
      fault     = 1'b0;
    end
  end

endmodule
`default_nettype wire
